spi_oversampled_slave: RTL and testbench

SPI mode-0 slave that oversamples the Raspberry Pi's SCLK/MOSI/CE0 pins with the icestick system clock, so every output lives entirely in the `clk` domain. It sits between the board SPI pins and the counter logic. It delivers each received byte as a one-cycle strobe and shifts out a byte supplied by the counter side. Supports multi-byte frames under one CE0 assertion.

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_oversampled_slave_sync_edge.sv | 43 ++++
 rtl/spi_oversampled_slave.sv | 157 +++++++++++++++
 tb/tb_spi_oversampled_slave.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the oversampled SPI slave: FSM encoding and default word width.
package spi_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_oversampled_slave_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, followed by registered
// rising/falling edge pulses in the clk domain.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], din};
    prev_d  = chain_q[SYNC_STAGES-1];
    rise_d  = chain_q[SYNC_STAGES-1] & ~prev_q;
    fall_d  = ~chain_q[SYNC_STAGES-1] & prev_q;
  end

  // Chain resets low so a pin already low at reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_oversampled_slave.sv
// SPI mode-0 slave that oversamples SCLK/MOSI/CE0 with clk; received words are
// strobed out with rx_valid, transmit words are fetched with a tx_ack pulse.
module spi_oversampled_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ce0,
  input  logic [DATA_W-1:0] tx_data,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_ack,
  output logic              busy,
  output logic              frame_err
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic rise, fall, ce_fall, ce_rise;
  logic s_mosi;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .rise (rise),
    .fall (fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ce0_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ce0),
    .rise (ce_rise),
    .fall (ce_fall)
  );

  // MOSI gets one flop less of delay than the edge pulses, so s_mosi is sampled
  // a cycle or two after the pin rise while the master still holds the bit.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  assign s_mosi = mosi_sync_q[SYNC_STAGES-1];

  spi_state_t        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              miso_q, miso_d;
  logic              tx_ack_d;
  logic [DATA_W-1:0] rx_shift;
  logic [CNT_W-1:0]  tx_idx;

  assign rx_shift = {rx_sr_q[DATA_W-2:0], s_mosi};
  assign tx_idx   = LAST_BIT - bit_cnt_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = miso_q;
    tx_ack_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (ce_fall) begin
          state_d   = ST_ACTIVE;
          tx_sr_d   = tx_data;
          tx_ack_d  = 1'b1;
          bit_cnt_d = '0;
          rx_sr_d   = '0;
          miso_d    = tx_data[DATA_W-1];
        end
      end

      ST_ACTIVE: begin
        // Deselect takes priority over any SCLK edge seen in the same cycle.
        if (ce_rise) begin
          state_d     = ST_IDLE;
          miso_d      = 1'b0;
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          rx_sr_d     = '0;
        end else if (rise) begin
          rx_sr_d = rx_shift;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_shift;
            rx_valid_d = 1'b1;
            tx_sr_d    = tx_data;
            tx_ack_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (fall) begin
          miso_d = tx_sr_q[tx_idx];
        end
      end

      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sync_q <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
    end
  end

  // tx_ack is decoded from registered edge pulses so the capture happens in the same cycle.
  assign tx_ack    = tx_ack_d;
  assign miso      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = (state_q == ST_ACTIVE);
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_oversampled_slave.sv
// Bench for spi_oversampled_slave: a mode-0 SPI master drives the pins while a
// monitor records strobes; expectations come from a byte-level model of the link.
module tb_spi_oversampled_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       ce0 = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ack;
  logic       busy;
  logic       frame_err;

  spi_oversampled_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .mosi      (mosi),
    .ce0       (ce0),
    .tx_data   (tx_data),
    .miso      (miso),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_ack    (tx_ack),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Link model state: bytes the master sends/reads and words the slave fetched.
  logic [7:0] mst_tx[$];
  logic [7:0] mst_rx[$];
  logic [7:0] tx_plan[$];
  logic [7:0] acked[$];
  logic [7:0] rx_got[$];
  int rx_valid_cnt, tx_ack_cnt, frame_err_cnt, width_err;
  logic miso_high_seen;
  logic busy_mid;

  task automatic clear_mon();
    rx_got.delete();
    acked.delete();
    rx_valid_cnt = 0;
    tx_ack_cnt = 0;
    frame_err_cnt = 0;
    width_err = 0;
    miso_high_seen = 1'b0;
  endtask

  initial begin : monitor
    logic prev_rv, prev_fe;
    prev_rv = 1'b0;
    prev_fe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (miso === 1'b1) miso_high_seen = 1'b1;
        if (rx_valid === 1'b1) begin
          rx_valid_cnt++;
          rx_got.push_back(rx_data);
          if (prev_rv === 1'b1) width_err++;
        end
        if (frame_err === 1'b1) begin
          frame_err_cnt++;
          if (prev_fe === 1'b1) width_err++;
        end
        prev_rv = rx_valid;
        prev_fe = frame_err;
        if (tx_ack === 1'b1) begin
          tx_ack_cnt++;
          acked.push_back(tx_data);
          @(posedge clk);
          #1;
          if (tx_plan.size() > 0) tx_data = tx_plan.pop_front();
        end
      end else begin
        prev_rv = 1'b0;
        prev_fe = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master: mosi changes while SCLK is low; miso is read late in the high phase.
  task automatic spi_frame(input int half, input int nbits);
    logic [7:0] cur;
    logic [7:0] rb;
    rb = 8'h00;
    mst_rx.delete();
    ce0 = 1'b0;
    wait_clks(6);
    busy_mid = busy;
    for (int i = 0; i < nbits; i++) begin
      cur  = mst_tx[i / 8];
      mosi = cur[7 - (i % 8)];
      wait_clks(half);
      sclk = 1'b1;
      wait_clks(half - 1);
      rb = {rb[6:0], miso};
      wait_clks(1);
      sclk = 1'b0;
      if ((i % 8) == 7) mst_rx.push_back(rb);
    end
    wait_clks(half);
    ce0  = 1'b1;
    mosi = 1'b0;
    wait_clks(12);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clks(3);
    total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", rx_data); else pass_cnt++;
    total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b want 0", rx_valid); else pass_cnt++;
    total_cnt++; if (tx_ack !== 1'b0) $display("FAIL reset_tx_ack got %b want 0", tx_ack); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else pass_cnt++;
    total_cnt++; if (miso !== 1'b0) $display("FAIL reset_miso got %b want 0", miso); else pass_cnt++;
    rst = 1'b0;
    wait_clks(10);
    clear_mon();
  endtask

  task automatic test_single_frame();
    clear_mon();
    tx_data = 8'h3C;
    mst_tx = '{8'hA5};
    spi_frame(4, 8);
    $display("single: sent A5 rx_data=%h master_read=%h tx_acks=%0d", rx_data, mst_rx[0], tx_ack_cnt);
    total_cnt++; if (busy_mid !== 1'b1) $display("FAIL single_busy got %b want 1", busy_mid); else pass_cnt++;
    total_cnt++; if (rx_data !== 8'hA5) $display("FAIL single_rx_data got %h want a5", rx_data); else pass_cnt++;
    total_cnt++; if (rx_valid_cnt != 1) $display("FAIL single_rx_valid_cnt got %0d want 1", rx_valid_cnt); else pass_cnt++;
    total_cnt++; if (mst_rx[0] !== 8'h3C) $display("FAIL single_miso_byte got %h want 3c", mst_rx[0]); else pass_cnt++;
    total_cnt++; if (tx_ack_cnt != 2) $display("FAIL single_tx_ack_cnt got %0d want 2", tx_ack_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || miso !== 1'b0) $display("FAIL single_idle_after got busy=%b miso=%b want 0 0", busy, miso); else pass_cnt++;
  endtask

  task automatic test_two_byte();
    clear_mon();
    tx_data = 8'h81;
    tx_plan = '{8'h7E};
    mst_tx = '{8'h01, 8'hFF};
    spi_frame(5, 16);
    $display("two_byte: rx_valids=%0d master_read=%h %h", rx_valid_cnt, mst_rx[0], mst_rx[1]);
    total_cnt++; if (rx_valid_cnt != 2) $display("FAIL two_rx_valid_cnt got %0d want 2", rx_valid_cnt); else pass_cnt++;
    total_cnt++; if (rx_got.size() != 2 || rx_got[0] !== 8'h01 || rx_got[1] !== 8'hFF)
      $display("FAIL two_rx_words got %p want 01 ff", rx_got); else pass_cnt++;
    total_cnt++; if (mst_rx[0] !== 8'h81 || mst_rx[1] !== 8'h7E)
      $display("FAIL two_miso_bytes got %h %h want 81 7e", mst_rx[0], mst_rx[1]); else pass_cnt++;
  endtask

  task automatic test_abort();
    clear_mon();
    tx_data = 8'hC3;
    mst_tx = '{8'hF0};
    spi_frame(4, 5);
    $display("abort: frame_err=%0d rx_valid=%0d rx_data=%h", frame_err_cnt, rx_valid_cnt, rx_data);
    total_cnt++; if (frame_err_cnt != 1) $display("FAIL abort_frame_err_cnt got %0d want 1", frame_err_cnt); else pass_cnt++;
    total_cnt++; if (rx_valid_cnt != 0) $display("FAIL abort_rx_valid_cnt got %0d want 0", rx_valid_cnt); else pass_cnt++;
    total_cnt++; if (rx_data !== 8'hFF) $display("FAIL abort_rx_data got %h want ff", rx_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || miso !== 1'b0) $display("FAIL abort_idle got busy=%b miso=%b want 0 0", busy, miso); else pass_cnt++;
    total_cnt++; if (width_err != 0) $display("FAIL abort_pulse_width got %0d long pulses want 0", width_err); else pass_cnt++;
  endtask

  task automatic test_sclk_no_ce();
    clear_mon();
    ce0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mosi = i[0];
      sclk = ~sclk;
      wait_clks(4);
    end
    sclk = 1'b0;
    wait_clks(10);
    $display("no_ce: rx_valid=%0d tx_ack=%0d frame_err=%0d", rx_valid_cnt, tx_ack_cnt, frame_err_cnt);
    total_cnt++; if (rx_valid_cnt + tx_ack_cnt + frame_err_cnt != 0)
      $display("FAIL no_ce_strobes got %0d/%0d/%0d want 0/0/0", rx_valid_cnt, tx_ack_cnt, frame_err_cnt); else pass_cnt++;
    total_cnt++; if (miso_high_seen !== 1'b0) $display("FAIL no_ce_miso got high want 0"); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    clear_mon();
    b = 8'hB6;
    tx_data = 8'hFF;
    ce0 = 1'b0;
    wait_clks(6);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        rst = 1'b1;
        #1;
        total_cnt++; if ({miso, rx_data, rx_valid, tx_ack, busy, frame_err} !== 13'h0)
          $display("FAIL midrst_outputs got miso=%b rx=%h rv=%b ack=%b busy=%b fe=%b want all 0",
                   miso, rx_data, rx_valid, tx_ack, busy, frame_err); else pass_cnt++;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(1);
        clear_mon();
      end
      mosi = b[7 - i];
      wait_clks(4);
      sclk = 1'b1;
      wait_clks(4);
      sclk = 1'b0;
    end
    wait_clks(4);
    ce0 = 1'b1;
    wait_clks(12);
    $display("midrst: after release rx_valid=%0d tx_ack=%0d frame_err=%0d", rx_valid_cnt, tx_ack_cnt, frame_err_cnt);
    total_cnt++; if (rx_valid_cnt + tx_ack_cnt + frame_err_cnt != 0)
      $display("FAIL midrst_ignored got %0d/%0d/%0d want 0/0/0", rx_valid_cnt, tx_ack_cnt, frame_err_cnt); else pass_cnt++;
    total_cnt++; if (rx_data !== 8'h00) $display("FAIL midrst_rx_data got %h want 00", rx_data); else pass_cnt++;
    clear_mon();
    mst_tx = '{8'h5A};
    spi_frame(4, 8);
    $display("midrst: next frame rx_data=%h", rx_data);
    total_cnt++; if (rx_valid_cnt != 1 || rx_data !== 8'h5A)
      $display("FAIL midrst_next_frame got %0d valids data %h want 1 5a", rx_valid_cnt, rx_data); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    clear_mon();
    tx_data = 8'h00;
    mst_tx = '{8'h00, 8'h55, 8'hAA, 8'hFF};
    spi_frame(4, 32);
    $display("b2b: rx_words=%p width_err=%0d", rx_got, width_err);
    total_cnt++; if (rx_got.size() != 4) $display("FAIL b2b_count got %0d want 4", rx_got.size());
    else begin
      if (rx_got[0] !== 8'h00 || rx_got[1] !== 8'h55 || rx_got[2] !== 8'hAA || rx_got[3] !== 8'hFF)
        $display("FAIL b2b_order got %p want 00 55 aa ff", rx_got);
      else pass_cnt++;
    end
    total_cnt++; if (width_err != 0) $display("FAIL b2b_pulse_width got %0d long pulses want 0", width_err); else pass_cnt++;
  endtask

  task automatic test_random();
    int n, half, bad;
    for (int f = 0; f < 5; f++) begin
      clear_mon();
      n = $urandom_range(1, 3);
      half = $urandom_range(4, 6);
      mst_tx.delete();
      tx_plan.delete();
      tx_data = 8'($urandom);
      for (int k = 0; k < n; k++) begin
        mst_tx.push_back(8'($urandom));
        tx_plan.push_back(8'($urandom));
      end
      spi_frame(half, n * 8);
      $display("random frame %0d: bytes=%0d half=%0d sent=%p got=%p", f, n, half, mst_tx, rx_got);
      bad = 0;
      if (rx_got.size() != n || mst_rx.size() != n || acked.size() < n) bad = 1;
      else begin
        for (int k = 0; k < n; k++) begin
          if (rx_got[k] !== mst_tx[k]) bad++;
          if (mst_rx[k] !== acked[k]) bad++;
        end
      end
      total_cnt++; if (bad != 0) $display("FAIL random_data frame %0d got rx=%p miso=%p want rx=%p miso=%p",
                                          f, rx_got, mst_rx, mst_tx, acked); else pass_cnt++;
      total_cnt++; if (tx_ack_cnt != n + 1 || frame_err_cnt != 0 || width_err != 0)
        $display("FAIL random_strobes frame %0d got ack=%0d fe=%0d werr=%0d want ack=%0d fe=0 werr=0",
                 f, tx_ack_cnt, frame_err_cnt, width_err, n + 1); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_two_byte();
    test_abort();
    test_sclk_no_ce();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
